sd_sender: RTL
==============

Name: sd_sender

Overview:
SPI transmit stage of the SD controller, sitting upstream of the card; the card's reply is consumed by sd_receiver2.
- Serializes either a 48-bit command frame or a 512-byte data block onto MOSI, MSB first, one bit per clock.
- Generates CRC7 for command frames and CRC16-CCITT for data blocks on the fly.
- Handshakes with the controller through valid/ready.

Parameters:
- DATA_BITS, 4096, data block payload length in bits; must be a multiple of 8.

Ports:
- clock  input  1  system clock; MOSI bit rate equals clock rate.
- reset  input  1  asynchronous, active-low reset.
- valid  input  1  controller request; sampled only while ready=1.
- ready  output  1  high when idle and able to accept a request.
- send_data  input  1  0: command frame, 1: data block.
- cmd_index  input  6  command index (CMDn), used when send_data=0.
- argument  input  32  command argument, used when send_data=0.
- data_block  input  DATA_BITS  block payload; bit DATA_BITS-1 is sent first.
- mosi  output  1  serial data to the card.

Behaviour:
- Reset (asynchronous, active-low): state=Idle, ready=1, mosi=1, CRC and counter cleared. Asserting reset mid-frame aborts at once; the frame is not resumed.
- States: Idle(00), Payload(01), Crc(10), Stop(11).
- Idle:
  - ready=1, mosi=1.
  - On a clock edge with valid&ready, latch all inputs into the shift register, clear the CRC, load the bit counter, and move to Payload.
  - Inputs that change after the handshake are ignored.
- mosi is the shift-register MSB while in Payload or Crc, and 1 in Idle and Stop.
  - The first frame bit appears in the cycle after the handshake edge.
- Command frame:
  - Payload: 40 bits = 0,1,cmd_index[5:0],argument[31:0].
  - Crc: 7 bits of CRC7.
  - Stop: end bit 1 for one cycle.
  - Total 48 cycles; ready returns high in the 49th cycle after the handshake.
- Data block:
  - Payload: token 8'hFE, then DATA_BITS payload bits.
  - Crc: 16 bits of CRC16.
  - Stop: one cycle of mosi=1.
  - Total 8+DATA_BITS+17 cycles, i.e. 4121 with the default.
- CRC7:
  - Polynomial x^7+x^3+1, initial value 0, serial LFSR.
  - Updated with every bit shifted out in Payload for commands; all 40 bits are covered.
- CRC16:
  - Polynomial x^16+x^12+x^5+1, initial value 0.
  - Updated only on payload bits; the FE token is excluded.
  - CRC bits are sent MSB first.
- Transitions:
  - Payload→Crc when the counter reaches 0, at which point the CRC is loaded into the shift-register top.
  - Crc→Stop when the counter reaches 0 again.
  - Stop→Idle unconditionally.
- valid held high continuously: a new frame starts only after one Idle cycle; frames are never back-to-back.
- Bit counter is 13 bits wide, reloaded with 6 (CRC7) or 15 (CRC16) on entering Crc.

Optional Feature:
- Macro SD_SENDER_DEBUG_EN.
- Defined: adds output port sender_state[1:0] carrying the FSM state encoding above.
- Undefined: port absent, behaviour otherwise identical.

Decomposition:
- Package sd_pkg holds:
  - FSM state encodings;
  - frame lengths CMD_PAYLOAD_BITS=40, CRC7_BITS=7, CRC16_BITS=16;
  - DATA_START_TOKEN=8'hFE;
  - CRC polynomial constants, shared with sd_receiver2.
- One sub-module: sd_crc_lfsr.
  - Parameterized WIDTH and POLY, with inputs clear, enable, bit_in.
  - Instantiated twice (7 and 16) or once with a mux.
- Bit counting reuses sync_parallel_counter.

Test Plan:
- CMD0, argument 0 → mosi stream 40 00 00 00 00 95 (CRC7=0x4A); ready low 48 cycles, high on the 49th.
- CMD8, argument 0x000001AA → stream 48 00 00 01 AA 87.
- CMD17, argument 0 → stream 51 00 00 00 00 55; inputs changed during transmission must not alter the stream.
- Data block of 512×0xFF → FE, 4096 ones, CRC 7F A1, then mosi=1; 4121 busy cycles.
- Data block of all zeros → CRC 00 00.
- Reset pulled low at bit 20 of CMD8 → mosi=1 and ready=1 immediately. After release, a CMD0 request transmits the correct full frame.

Source files
------------

// File: rtl/sd_pkg.sv
// ---------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the SD SPI transmit/receive path (sd_sender,
// sd_receiver2): FSM state encodings, frame field lengths, the data start
// token and the CRC generator polynomials (leading term implied).
// No ports; imported with "import sd_pkg::*;".
// ---------------------------------------------------------------------------
package sd_pkg;

  // Transmit FSM states; the encoding is visible on the debug port
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PAYLOAD = 2'b01,
    ST_CRC     = 2'b10,
    ST_STOP    = 2'b11
  } sd_state_t;

  localparam int CMD_PAYLOAD_BITS = 40;
  localparam int CRC7_BITS        = 7;
  localparam int CRC16_BITS       = 16;
  localparam int TOKEN_BITS       = 8;
  localparam int SD_CNT_BITS      = 13;

  localparam logic [7:0] DATA_START_TOKEN = 8'hFE;

  // x^7 + x^3 + 1 and x^16 + x^12 + x^5 + 1, top term dropped
  localparam logic [6:0]  CRC7_POLY  = 7'h09;
  localparam logic [15:0] CRC16_POLY = 16'h1021;

endpackage

// File: rtl/sd_crc_lfsr.sv
// ---------------------------------------------------------------------------
// sd_crc_lfsr
// Serial MSB-first CRC generator (Galois LFSR), initial value zero.
// Ports:
//   clock    - system clock
//   reset    - asynchronous active-low reset, clears the CRC
//   clear    - synchronous clear, takes priority over enable
//   enable   - fold bit_in into the CRC on this clock
//   bit_in   - serial message bit
//   crc_next - CRC value after this clock edge; with enable and clear low it
//              equals the stored CRC, so it doubles as the current value
// ---------------------------------------------------------------------------
module sd_crc_lfsr #(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] POLY  = 7'h09
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             bit_in,
  output logic [WIDTH-1:0] crc_next
);

  logic [WIDTH-1:0] crc_q;

  // Next-state of the LFSR: feedback is the incoming bit XOR the CRC MSB
  always_comb begin
    crc_next = crc_q;
    if (clear) begin
      crc_next = '0;
    end else if (enable) begin
      crc_next = {crc_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{bit_in ^ crc_q[WIDTH-1]}} & POLY);
    end
  end

  // CRC register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_next;
    end
  end

endmodule

// File: rtl/sync_parallel_counter.sv
// ---------------------------------------------------------------------------
// sync_parallel_counter
// Down counter with synchronous parallel load.
// Ports:
//   clock      - system clock
//   reset      - asynchronous active-low reset, clears the count
//   load       - load load_value (priority over enable)
//   enable     - decrement by one
//   load_value - value to load
//   count      - current count
// ---------------------------------------------------------------------------
module sync_parallel_counter #(
  parameter int WIDTH = 13
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count
);

  // Load wins over decrement so a reload on the terminal cycle is clean
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/sd_sender.sv
// ---------------------------------------------------------------------------
// sd_sender
// SPI transmit stage of the SD controller. Serializes a 48-bit command frame
// (0,1,index,argument,CRC7,1) or a data block (FE token, payload, CRC16, 1)
// onto mosi, MSB first, one bit per clock, with the CRC computed on the fly.
// Ports:
//   clock        - system clock (mosi bit rate)
//   reset        - asynchronous active-low reset; aborts any frame
//   valid        - request, sampled only while ready is high
//   ready        - idle, request can be accepted
//   send_data    - 0: command frame, 1: data block
//   cmd_index    - command index (command frames)
//   argument     - command argument (command frames)
//   data_block   - block payload, bit DATA_BITS-1 sent first
//   mosi         - serial data to the card, idles high
//   sender_state - FSM state, present only with SD_SENDER_DEBUG_EN defined
// ---------------------------------------------------------------------------
module sd_sender
  import sd_pkg::*;
#(
  parameter int DATA_BITS = 4096
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 valid,
  output logic                 ready,
  input  logic                 send_data,
  input  logic [5:0]           cmd_index,
  input  logic [31:0]          argument,
  input  logic [DATA_BITS-1:0] data_block,
  output logic                 mosi
`ifdef SD_SENDER_DEBUG_EN
  ,
  output logic [1:0]           sender_state
`endif
);

  localparam int BLOCK_BITS = TOKEN_BITS + DATA_BITS;
  localparam int SR_W = (BLOCK_BITS > CMD_PAYLOAD_BITS) ? BLOCK_BITS : CMD_PAYLOAD_BITS;

  // Counter reload values are "bits remaining minus one"
  localparam logic [SD_CNT_BITS-1:0] CMD_LOAD   = SD_CNT_BITS'(CMD_PAYLOAD_BITS - 1);
  localparam logic [SD_CNT_BITS-1:0] BLOCK_LOAD = SD_CNT_BITS'(BLOCK_BITS - 1);
  localparam logic [SD_CNT_BITS-1:0] CRC7_LOAD  = SD_CNT_BITS'(CRC7_BITS - 1);
  localparam logic [SD_CNT_BITS-1:0] CRC16_LOAD = SD_CNT_BITS'(CRC16_BITS - 1);
  localparam logic [SD_CNT_BITS-1:0] DATA_CNT   = SD_CNT_BITS'(DATA_BITS);

  sd_state_t              state;
  logic [SR_W-1:0]        shift_reg;
  logic [SR_W-1:0]        cmd_frame;
  logic [SR_W-1:0]        block_frame;
  logic [SR_W-1:0]        crc7_frame;
  logic [SR_W-1:0]        crc16_frame;
  logic                   is_data;
  logic                   handshake;
  logic                   last_bit;
  logic                   cnt_load;
  logic                   cnt_en;
  logic [SD_CNT_BITS-1:0] cnt_value;
  logic [SD_CNT_BITS-1:0] count;
  logic                   crc7_en;
  logic                   crc16_en;
  logic [6:0]             crc7_next;
  logic [15:0]            crc16_next;

  assign handshake = (state == ST_IDLE) && valid;
  assign last_bit  = (count == '0);
  assign ready     = (state == ST_IDLE);
  assign mosi      = ((state == ST_PAYLOAD) || (state == ST_CRC)) ? shift_reg[SR_W-1] : 1'b1;

  // Frames are left-aligned so the shift register MSB is always the next bit
  assign cmd_frame   = SR_W'({2'b01, cmd_index, argument}) << (SR_W - CMD_PAYLOAD_BITS);
  assign block_frame = SR_W'({DATA_START_TOKEN, data_block}) << (SR_W - BLOCK_BITS);
  assign crc7_frame  = SR_W'(crc7_next) << (SR_W - CRC7_BITS);
  assign crc16_frame = SR_W'(crc16_next) << (SR_W - CRC16_BITS);

  // The token occupies counts above DATA_BITS-1, so it never reaches CRC16
  assign crc7_en  = (state == ST_PAYLOAD) && !is_data;
  assign crc16_en = (state == ST_PAYLOAD) && is_data && (count < DATA_CNT);

  sd_crc_lfsr #(.WIDTH(CRC7_BITS), .POLY(CRC7_POLY)) u_crc7 (
    .clock    (clock),
    .reset    (reset),
    .clear    (handshake),
    .enable   (crc7_en),
    .bit_in   (shift_reg[SR_W-1]),
    .crc_next (crc7_next)
  );

  sd_crc_lfsr #(.WIDTH(CRC16_BITS), .POLY(CRC16_POLY)) u_crc16 (
    .clock    (clock),
    .reset    (reset),
    .clear    (handshake),
    .enable   (crc16_en),
    .bit_in   (shift_reg[SR_W-1]),
    .crc_next (crc16_next)
  );

  // Counter reloads on the handshake and again when entering the CRC phase;
  // it stops at zero so it rests there in Stop and Idle
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = '0;
    if (handshake) begin
      cnt_load  = 1'b1;
      cnt_value = send_data ? BLOCK_LOAD : CMD_LOAD;
    end else if ((state == ST_PAYLOAD) && last_bit) begin
      cnt_load  = 1'b1;
      cnt_value = is_data ? CRC16_LOAD : CRC7_LOAD;
    end
  end

  assign cnt_en = ((state == ST_PAYLOAD) || (state == ST_CRC)) && !last_bit;

  sync_parallel_counter #(.WIDTH(SD_CNT_BITS)) u_bit_cnt (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .enable     (cnt_en),
    .load_value (cnt_value),
    .count      (count)
  );

  // Transmit FSM. On the last payload bit the CRC including that bit
  // (crc_next) is loaded into the top of the shift register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      is_data   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid) begin
            is_data   <= send_data;
            shift_reg <= send_data ? block_frame : cmd_frame;
            state     <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (last_bit) begin
            shift_reg <= is_data ? crc16_frame : crc7_frame;
            state     <= ST_CRC;
          end else begin
            shift_reg <= shift_reg << 1;
          end
        end
        ST_CRC: begin
          shift_reg <= shift_reg << 1;
          if (last_bit) begin
            state <= ST_STOP;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SD_SENDER_DEBUG_EN
  assign sender_state = state;
`endif

endmodule
